// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard, branch-wait/flush sequencing, stall counter.
// Optional write-back bypass of the hazard check is enabled by defining HAZARD_WB_BYPASS_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_branch,
  input  logic        ex_br_valid,
  input  logic        ex_br_taken,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dst,
  output logic        stall,
  output logic        issue,
  output logic        flush,
  output logic [15:0] pending,
  output logic [7:0]  stall_cnt
);

  // state   | meaning
  // RUN     | normal issue, stalls only on scoreboard hazards
  // BR_WAIT | branch issued, decode held until ex resolves it
  // FLUSH   | taken branch: squash fetch/decode for one cycle
  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [15:0] wb_mask;
  logic [15:0] set_mask;
  logic [15:0] pend_chk;
  logic [15:0] pending_nxt;
  logic        hazard;

  assign wb_mask = wb_valid ? (16'h0001 << wb_dst) : 16'h0000;

`ifdef HAZARD_WB_BYPASS_EN
  assign pend_chk = pending & ~wb_mask;
`else
  assign pend_chk = pending;
`endif

  // Bit 0 of pending is never set, so R0 can never raise a hazard.
  assign hazard = id_valid &&
                  ((id_use1     && pend_chk[id_src1]) ||
                   (id_use2     && pend_chk[id_src2]) ||
                   (id_regwrite && pend_chk[id_dst]));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          issue = id_valid && !hazard;
          stall = hazard;
          if (issue && id_branch) state_nxt = BR_WAIT;
        end
        BR_WAIT: begin
          stall = id_valid;
          if (ex_br_valid) state_nxt = ex_br_taken ? FLUSH : RUN;
        end
        FLUSH: begin
          flush     = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign set_mask    = (issue && id_regwrite && (id_dst != 4'd0)) ? (16'h0001 << id_dst) : 16'h0000;
  assign pending_nxt = ((pending & ~wb_mask) | set_mask) & 16'hFFFE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      pending   <= 16'h0000;
      stall_cnt <= 8'h00;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (stall && (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic vs. a behavioural model.
// Honours HAZARD_WB_BYPASS_EN in the model the same way as the design build.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use1, id_use2, id_regwrite, id_branch;
  logic [3:0]  id_src1, id_src2, id_dst, wb_dst;
  logic        ex_br_valid, ex_br_taken, wb_valid;
  logic        stall, issue, flush;
  logic [15:0] pending;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model
  bit m_pend[16];
  int m_cnt;
  bit m_wait_branch;
  bit m_flush_due;
  bit e_stall, e_issue, e_flush;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_branch(id_branch),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .stall(stall), .issue(issue), .flush(flush),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
    m_cnt = 0;
    m_wait_branch = 0;
    m_flush_due = 0;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_regwrite = 0; id_branch = 0;
    id_src1 = 0; id_src2 = 0; id_dst = 0;
    ex_br_valid = 0; ex_br_taken = 0; wb_valid = 0; wb_dst = 0;
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic cycle();
    bit seen[16];
    bit hz;
    #1;
    for (int i = 0; i < 16; i++) seen[i] = m_pend[i];
`ifdef HAZARD_WB_BYPASS_EN
    if (wb_valid) seen[wb_dst] = 0;
`endif
    hz = id_valid && ((id_use1 && seen[id_src1]) || (id_use2 && seen[id_src2]) ||
                      (id_regwrite && seen[id_dst]));
    e_stall = 0; e_issue = 0; e_flush = 0;
    if (rst) begin
      if (m_flush_due) e_flush = 1;
      else if (m_wait_branch) e_stall = id_valid;
      else begin
        e_issue = id_valid && !hz;
        e_stall = hz;
      end
    end
    check("stall", 32'(stall), 32'(e_stall));
    check("issue", 32'(issue), 32'(e_issue));
    check("flush", 32'(flush), 32'(e_flush));
    check("pending", 32'(pending), 32'(model_pending()));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (wb_valid) m_pend[wb_dst] = 0;
      if (e_issue && id_regwrite && id_dst != 0) m_pend[id_dst] = 1;
      if (e_stall && m_cnt < 255) m_cnt++;
      if (m_flush_due) m_flush_due = 0;
      else if (m_wait_branch) begin
        if (ex_br_valid) begin
          m_wait_branch = 0;
          m_flush_due = ex_br_taken;
        end
      end else if (e_issue && id_branch) m_wait_branch = 1;
    end
    @(negedge clk);
  endtask

  task automatic issue_write(input logic [3:0] dst);
    idle_inputs();
    id_valid = 1; id_regwrite = 1; id_dst = dst;
    cycle();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1;

    // RAW on R3 held until write-back
    issue_write(4'd3);
    idle_inputs();
    id_valid = 1; id_use1 = 1; id_src1 = 4'd3;
    repeat (3) cycle();
    check("raw_stalled", 32'(stall), 32'd1);
    wb_valid = 1; wb_dst = 4'd3;
    cycle();
    wb_valid = 0;
    cycle();
    check("raw_pending_clear", 32'(pending[3]), 32'd0);

    // R0 writes never tracked, R0 reads never stall
    issue_write(4'd0);
    check("r0_pending", 32'(pending), 32'h0);
    idle_inputs();
    id_valid = 1; id_use1 = 1; id_use2 = 1; id_src1 = 0; id_src2 = 0;
    cycle();

    // taken branch: BR_WAIT stall, one flush cycle
    idle_inputs();
    id_valid = 1; id_branch = 1;
    cycle();
    id_branch = 0;
    cycle();
    ex_br_valid = 1; ex_br_taken = 1;
    cycle();
    ex_br_valid = 0; ex_br_taken = 0;
    cycle();
    cycle();

    // not-taken branch
    id_branch = 1;
    cycle();
    id_branch = 0;
    ex_br_valid = 1;
    cycle();
    ex_br_valid = 0;
    cycle();
    cycle();

    // same-cycle set and clear of R5
    idle_inputs();
    id_valid = 1; id_regwrite = 1; id_dst = 4'd5; wb_valid = 1; wb_dst = 4'd5;
    cycle();
    idle_inputs();
    cycle();
    check("set_wins_r5", 32'(pending[5]), 32'd1);
    wb_valid = 1; wb_dst = 4'd5;
    cycle();

    // saturate the stall counter on a long hazard
    issue_write(4'd7);
    idle_inputs();
    id_valid = 1; id_use2 = 1; id_src2 = 4'd7;
    repeat (300) cycle();
    check("stall_cnt_sat", 32'(stall_cnt), 32'hFF);

    // reset in BR_WAIT abandons the branch
    idle_inputs();
    wb_valid = 1; wb_dst = 4'd7;
    cycle();
    idle_inputs();
    id_valid = 1; id_branch = 1;
    cycle();
    rst = 0; ex_br_valid = 1; ex_br_taken = 1; id_branch = 0;
    cycle();
    rst = 1; ex_br_valid = 0; ex_br_taken = 0;
    check("rst_pending", 32'(pending), 32'h0);
    repeat (3) cycle();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(99) != 0);
      id_valid    = ($urandom_range(3) != 0);
      id_src1     = 4'($urandom_range(7));
      id_src2     = 4'($urandom_range(7));
      id_dst      = 4'($urandom_range(7));
      id_use1     = 1'($urandom);
      id_use2     = 1'($urandom);
      id_regwrite = 1'($urandom);
      id_branch   = ($urandom_range(7) == 0);
      ex_br_valid = ($urandom_range(2) == 0);
      ex_br_taken = 1'($urandom);
      wb_valid    = ($urandom_range(9) < 4);
      wb_dst      = 4'($urandom_range(7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- id_valid  in  1  decode stage holds a valid instruction.
- id_src1  in  4  source register 1 (instr[7:4]).
- id_src2  in  4  source register 2, already muxed by RegSrc.
- id_use1, id_use2  in  1 each  instruction reads src1/src2.
- id_dst  in  4  destination register.
- id_regwrite  in  1  instruction writes id_dst.
- id_branch  in  1  instruction is B or BR.
- ex_br_valid  in  1  branch resolved this cycle.
- ex_br_taken  in  1  resolved branch is taken; qualified by ex_br_valid.
- wb_valid  in  1  register file write this cycle.
- wb_dst  in  4  register written.
- stall  out  1  hold PC and decode this cycle.
- issue  out  1  decode instruction advances this cycle.
- flush  out  1  squash fetch/decode contents this cycle.
- pending  out  16  scoreboard; bit n set means register n has an outstanding write.
- stall_cnt  out  8  saturating count of stall cycles.

Function
REQ-002 The hazard condition SHALL be id_valid AND any of: (id_use1 and pending[id_src1]), (id_use2 and pending[id_src2]), or (id_regwrite and pending[id_dst]) (WAW).
REQ-003 Register 0 SHALL never be set in pending and SHALL never cause a hazard.
REQ-004 The FSM SHALL have three states: RUN, BR_WAIT, FLUSH.
REQ-005 In RUN: issue = id_valid and not hazard; stall = id_valid and hazard; flush = 0.
REQ-006 When issue=1 with id_branch=1, the next state SHALL be BR_WAIT; otherwise the FSM SHALL stay in RUN.
REQ-007 In BR_WAIT: issue = 0; stall = id_valid.
REQ-008 In BR_WAIT, ex_br_valid with ex_br_taken SHALL go to FLUSH; ex_br_valid without ex_br_taken SHALL go to RUN; with no ex_br_valid the FSM SHALL stay in BR_WAIT.
REQ-009 FLUSH SHALL last exactly one cycle: flush = 1, issue = 0, stall = 0; next state RUN.
REQ-010 An issue with id_regwrite=1 and id_dst != 0 SHALL set pending[id_dst] at the next edge.
REQ-011 wb_valid SHALL clear pending[wb_dst] at the next edge.
REQ-012 When set and clear target the same register in the same cycle, set SHALL win.
REQ-013 wb_valid SHALL be honoured in every state, including FLUSH.
REQ-014 pending SHALL NOT be cleared by flush; only wb_valid or reset clears bits.
REQ-015 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 8'hFF.
REQ-016 stall, issue and flush SHALL be combinational from current state and inputs; pending and stall_cnt SHALL be registered.
REQ-017 ex_br_valid outside BR_WAIT SHALL be ignored.

Reset
REQ-018 While rst=0 at a clock edge, the block SHALL set: state = RUN, pending = 16'h0000, stall_cnt = 8'h00.
REQ-019 During reset cycles, issue, stall and flush SHALL be driven 0.
REQ-020 Reset asserted mid-BR_WAIT or mid-FLUSH SHALL abandon the operation, with no flush emitted afterwards.

Configuration
REQ-021 The macro HAZARD_WB_BYPASS_EN SHALL select write-back bypass.
- Defined: the hazard check SHALL use pending with the same-cycle wb_dst bit masked, so a source written back this cycle does not stall.
- Undefined: the hazard check SHALL use registered pending only, costing one extra stall cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Issue R3 write, then next cycle id_src1=3 use1=1 -> stall=1 until wb_valid wb_dst=3; issue the cycle after wb (bypass off) or the same cycle (bypass on).
- id_regwrite id_dst=0 issued -> pending stays 16'h0000; later read of R0 -> no stall.
- Branch issued, ex_br_valid=1 ex_br_taken=1 two cycles later -> stall during BR_WAIT, flush=1 exactly one cycle, then RUN.
- Branch not taken -> no flush; issue resumes the cycle after resolution.
- Same-cycle issue id_dst=5 and wb_valid wb_dst=5 (bypass on) -> pending[5]=1 afterward.
- Hold a hazard 300 cycles -> stall_cnt=8'hFF; rst=0 in BR_WAIT -> pending=0, state RUN, flush never asserts.
